// File: rtl/ps2_pkg.sv
//==============================================================================
// Module      : ps2_pkg
// Description : Shared constants, state encoding and parity helper for the
//               PS/2 key sender.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ps2_pkg;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ps2_state_e;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_key_sender_if.sv
//==============================================================================
// Module      : ps2_key_sender_if
// Description : Key-event request handshake plus the PS/2 line pair.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ps2_key_sender_if;

    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic       valid;
    logic       ready;
    logic       done;
    logic       ps2_clk;
    logic       ps2_data;

    modport master (
        output code, brk, ext, valid,
        input  ready, done, ps2_clk, ps2_data
    );

    modport slave (
        input  code, brk, ext, valid,
        output ready, done, ps2_clk, ps2_data
    );

endinterface

`default_nettype wire

// File: rtl/ps2_tx_frame.sv
//==============================================================================
// Module      : ps2_tx_frame
// Description : Serialises one byte as an 11-cell PS/2 frame (start, 8 data
//               LSB first, odd parity, stop) and generates ps2_clk.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_tx_frame
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 2500
) (
    input  wire logic       clk,
    input  wire logic       clrn,
    input  wire logic       i_load,
    input  wire logic [7:0] i_tx_byte,
    output logic            o_ps2_clk,
    output logic            o_ps2_data,
    output logic            o_frame_end
);

    localparam int                   c_HALF_W   = $clog2(HALF_PERIOD);
    localparam logic [c_HALF_W-1:0]  c_HALF_LAST = c_HALF_W'(HALF_PERIOD - 1);
    localparam int                   c_BIT_W    = $clog2(PS2_FRAME_BITS);
    localparam logic [c_BIT_W-1:0]   c_BIT_LAST = c_BIT_W'(PS2_FRAME_BITS - 1);

    logic                      r_active;
    logic                      r_phase;   // 0 = clock-high half, 1 = clock-low half
    logic [c_HALF_W-1:0]       r_half;
    logic [c_BIT_W-1:0]        r_bit;
    logic [PS2_FRAME_BITS-1:0] r_shift;
    logic                      r_ps2_clk;

    logic w_half_end;
    logic w_cell_end;

    assign w_half_end  = r_active && (r_half == c_HALF_LAST);
    assign w_cell_end  = w_half_end && r_phase;
    assign o_frame_end = w_cell_end && (r_bit == c_BIT_LAST);

    // The line bit is always the LSB of the shifter; ones fill in behind so
    // the line rests high once the stop bit has been shifted out.
    assign o_ps2_data = r_shift[0];
    assign o_ps2_clk  = r_ps2_clk;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_active  <= 1'b0;
            r_phase   <= 1'b0;
            r_half    <= '0;
            r_bit     <= '0;
            r_shift   <= '1;
            r_ps2_clk <= 1'b1;
        end else if (i_load) begin
            r_active  <= 1'b1;
            r_phase   <= 1'b0;
            r_half    <= '0;
            r_bit     <= '0;
            r_shift   <= {1'b1, odd_parity(i_tx_byte), i_tx_byte, 1'b0};
            r_ps2_clk <= 1'b1;
        end else if (r_active) begin
            if (w_half_end) begin
                r_half  <= '0;
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_ps2_clk <= 1'b0;
                end else begin
                    r_ps2_clk <= 1'b1;
                    r_shift   <= {1'b1, r_shift[PS2_FRAME_BITS-1:1]};
                    if (o_frame_end) begin
                        r_active <= 1'b0;
                        r_bit    <= '0;
                    end else begin
                        r_bit <= r_bit + 1'b1;
                    end
                end
            end else begin
                r_half <= r_half + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_key_sender.sv
//==============================================================================
// Module      : ps2_key_sender
// Description : Device-side PS/2 keyboard emulator: one key event per
//               handshake, sent as make code or F0-prefixed break sequence.
//               Define PS2_TX_EXT_EN to honour the ext flag (E0 prefix).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_key_sender
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 2500,
    parameter int GAP_CYCLES  = 5000
) (
    input  wire logic         clk,
    input  wire logic         clrn,
    ps2_key_sender_if.slave   bus
);

`ifdef PS2_TX_EXT_EN
    localparam int c_MAX_BYTES = 3;
`else
    localparam int c_MAX_BYTES = 2;
`endif
    localparam int                  c_IDX_W    = $clog2(c_MAX_BYTES);
    localparam int                  c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);

    ps2_state_e r_state;
    ps2_state_e w_state_next;

    logic [c_GAP_W-1:0]              r_gap_cnt;
    logic [c_IDX_W-1:0]              r_byte_idx;
    logic [c_IDX_W-1:0]              r_last_idx;
    logic [c_MAX_BYTES-1:0][7:0]     r_seq;
    logic                            r_done;

    logic [c_MAX_BYTES-1:0][7:0]     w_seq;
    logic [c_IDX_W-1:0]              w_last_idx;
    logic [c_IDX_W-1:0]              w_next_idx;
    logic                            w_accept;
    logic                            w_gap_end;
    logic                            w_more;
    logic                            w_load;
    logic [7:0]                      w_load_byte;
    logic                            w_frame_end;
    logic                            w_done_next;

    assign w_accept   = (r_state == IDLE) && bus.valid;
    assign w_gap_end  = (r_state == GAP) && (r_gap_cnt == c_GAP_LAST);
    assign w_more     = (r_byte_idx != r_last_idx);
    assign w_next_idx = r_byte_idx + 1'b1;

    // Byte sequence for the incoming event, first byte sent in slot 0.
    always_comb begin
        w_seq      = {c_MAX_BYTES{bus.code}};
        w_last_idx = '0;
`ifdef PS2_TX_EXT_EN
        if (bus.ext && bus.brk) begin
            w_seq[0]   = PS2_EXT_CODE;
            w_seq[1]   = PS2_BREAK_CODE;
            w_last_idx = c_IDX_W'(2);
        end else if (bus.ext) begin
            w_seq[0]   = PS2_EXT_CODE;
            w_last_idx = c_IDX_W'(1);
        end else if (bus.brk) begin
            w_seq[0]   = PS2_BREAK_CODE;
            w_last_idx = c_IDX_W'(1);
        end
`else
        // ext is masked off: it has no effect in this build.
        if (bus.brk | (bus.ext & 1'b0)) begin
            w_seq[0]   = PS2_BREAK_CODE;
            w_last_idx = c_IDX_W'(1);
        end
`endif
    end

    assign w_load      = w_accept || (w_gap_end && w_more);
    assign w_load_byte = w_accept ? w_seq[0] : r_seq[w_next_idx];

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE:  if (bus.valid) w_state_next = SHIFT;
            SHIFT: if (w_frame_end) w_state_next = GAP;
            GAP: begin
                if (w_gap_end) begin
                    if (w_more) begin
                        w_state_next = SHIFT;
                    end else begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= IDLE;
            r_gap_cnt  <= '0;
            r_byte_idx <= '0;
            r_last_idx <= '0;
            r_seq      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_done    <= w_done_next;
            r_gap_cnt <= (r_state == GAP && !w_gap_end) ? r_gap_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_seq      <= w_seq;
                r_last_idx <= w_last_idx;
                r_byte_idx <= '0;
            end else if (w_gap_end && w_more) begin
                r_byte_idx <= w_next_idx;
            end
        end
    end

    ps2_tx_frame #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_frame (
        .clk         (clk),
        .clrn        (clrn),
        .i_load      (w_load),
        .i_tx_byte   (w_load_byte),
        .o_ps2_clk   (bus.ps2_clk),
        .o_ps2_data  (bus.ps2_data),
        .o_frame_end (w_frame_end)
    );

    assign bus.ready = (r_state == IDLE);
    assign bus.done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_sender.sv
//==============================================================================
// Module      : tb_ps2_key_sender
// Description : Self-checking bench for ps2_key_sender (HALF_PERIOD=2,
//               GAP_CYCLES=4); honours PS2_TX_EXT_EN when defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ps2_key_sender;

    localparam int HP  = 2;
    localparam int GAP = 4;

    typedef struct packed {
        logic rdy;
        logic pc;
        logic pd;
        logic dn;
    } exp_t;

    logic clk;
    logic clrn;
    logic chk_en;
    int   n_vec;
    int   n_err;

    ps2_key_sender_if bus();

    ps2_key_sender #(
        .HALF_PERIOD (HP),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: per-cycle expected line levels
    exp_t e;
    exp_t q[$];
    logic pend_done;

    function automatic exp_t mk(input logic r, input logic c, input logic d, input logic n);
        exp_t t;
        t.rdy = r; t.pc = c; t.pd = d; t.dn = n;
        return t;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        f[0]    = 1'b0;
        f[8:1]  = b;
        f[9]    = (ones % 2 == 0);
        f[10]   = 1'b1;
        for (int i = 0; i < 11; i++) begin
            for (int h = 0; h < HP; h++) q.push_back(mk(1'b0, 1'b1, f[i], 1'b0));
            for (int h = 0; h < HP; h++) q.push_back(mk(1'b0, 1'b0, f[i], 1'b0));
        end
        for (int g = 0; g < GAP; g++) q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0));
    endtask

    task automatic push_event(input logic [7:0] c, input logic b, input logic x);
`ifdef PS2_TX_EXT_EN
        if (x) push_byte(8'hE0);
`else
        if (x) begin end
`endif
        if (b) push_byte(8'hF0);
        push_byte(c);
    endtask

    initial begin
        e = mk(1'b1, 1'b1, 1'b1, 1'b0);
        pend_done = 1'b0;
        forever begin
            @(posedge clk or negedge clrn);
            if (!clrn) begin
                q.delete();
                e = mk(1'b1, 1'b1, 1'b1, 1'b0);
                pend_done = 1'b0;
            end else begin
                if (e.rdy && bus.valid) push_event(bus.code, bus.brk, bus.ext);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    if (q.size() == 0) pend_done = 1'b1;
                end else begin
                    e = mk(1'b1, 1'b1, 1'b1, pend_done);
                    pend_done = 1'b0;
                end
            end
        end
    end

    // ---------------- compare process
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("ready",    32'(bus.ready),    32'(e.rdy));
                chk("ps2_clk",  32'(bus.ps2_clk),  32'(e.pc));
                chk("ps2_data", 32'(bus.ps2_data), 32'(e.pd));
                chk("done",     32'(bus.done),     32'(e.dn));
            end
        end
    end

    // ---------------- receiver: frames sampled on ps2_clk falling edges
    logic [10:0] rx_q[$];
    logic [10:0] rx_sh;
    int          rx_n;

    initial begin
        rx_n = 0;
        rx_sh = '0;
        forever begin
            @(negedge bus.ps2_clk or negedge clrn);
            if (!clrn) begin
                rx_n = 0;
            end else begin
                rx_sh[rx_n] = bus.ps2_data;
                rx_n++;
                if (rx_n == 11) begin
                    rx_q.push_back(rx_sh);
                    rx_n = 0;
                end
            end
        end
    end

    task automatic check_rx(input int n, input logic [10:0] f0, input logic [10:0] f1,
                            input logic [10:0] f2);
        logic [10:0] exp_f[3];
        exp_f[0] = f0; exp_f[1] = f1; exp_f[2] = f2;
        chk("rx_frame_count", 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++)
            chk("rx_frame_bits", 32'(rx_q[i]), 32'(exp_f[i]));
        rx_q.delete();
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (bus.done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: no done within %0d cycles", k);
        end
    endtask

    task automatic send(input logic [7:0] c, input logic b, input logic x, output int k);
        @(negedge clk);
        bus.code = c; bus.brk = b; bus.ext = x; bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        wait_done(k);
    endtask

    // ---------------- directed stimulus
    initial begin
        int k;
        n_vec = 0; n_err = 0; chk_en = 1'b0;
        clrn = 1'b0;
        bus.code = 8'h00; bus.brk = 1'b0; bus.ext = 1'b0; bus.valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready",    32'(bus.ready),    32'd1);
        chk("reset_ps2_clk",  32'(bus.ps2_clk),  32'd1);
        chk("reset_ps2_data", 32'(bus.ps2_data), 32'd1);
        chk("reset_done",     32'(bus.done),     32'd0);
        #2 clrn = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // press 1C: one frame, done 48 cycles after the start-bit cycle
        send(8'h1C, 1'b0, 1'b0, k);
        chk("press_done_latency", 32'(k), 32'd48);
        check_rx(1, 11'h438, 11'h0, 11'h0);

        // release 1C: F0 then 1C
        send(8'h1C, 1'b1, 1'b0, k);
        chk("release_done_latency", 32'(k), 32'd96);
        check_rx(2, 11'h7E0, 11'h438, 11'h0);

        // valid held high with code 55 during a press of 1C
        @(negedge clk);
        bus.code = 8'h1C; bus.brk = 1'b0; bus.ext = 1'b0; bus.valid = 1'b1;
        @(negedge clk);
        bus.code = 8'h55;
        wait_done(k);
        chk("hold_done_latency", 32'(k), 32'd48);
        @(negedge clk);
        chk("restart_start_bit", 32'(bus.ps2_data), 32'd0);
        chk("restart_ready",     32'(bus.ready),    32'd0);
        bus.valid = 1'b0;
        wait_done(k);
        chk("second_done_latency", 32'(k), 32'd48);
        check_rx(2, 11'h438, 11'h6AA, 11'h0);

        // reset during the clock-low half of bit cell 5
        @(negedge clk);
        bus.code = 8'h1C; bus.brk = 1'b0; bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
        repeat (22) @(negedge clk);
        chk("midframe_clk_low", 32'(bus.ps2_clk),  32'd0);
        chk("midframe_bit5",    32'(bus.ps2_data), 32'd1);
        #2 clrn = 1'b0;
        #1;
        chk("async_rst_ps2_clk",  32'(bus.ps2_clk),  32'd1);
        chk("async_rst_ps2_data", 32'(bus.ps2_data), 32'd1);
        chk("async_rst_ready",    32'(bus.ready),    32'd1);
        repeat (2) @(negedge clk);
        #2 clrn = 1'b1;
        @(negedge clk);
        check_rx(0, 11'h0, 11'h0, 11'h0);

        // loopback set after reset
        send(8'hFF, 1'b0, 1'b0, k);
        chk("ff_done_latency", 32'(k), 32'd48);
        check_rx(1, 11'h7FE, 11'h0, 11'h0);
        send(8'h00, 1'b0, 1'b0, k);
        check_rx(1, 11'h600, 11'h0, 11'h0);
        send(8'h1C, 1'b1, 1'b0, k);
        check_rx(2, 11'h7E0, 11'h438, 11'h0);

        // extended release of 75
        send(8'h75, 1'b1, 1'b1, k);
`ifdef PS2_TX_EXT_EN
        chk("ext_done_latency", 32'(k), 32'd144);
        check_rx(3, 11'h5C0, 11'h7E0, 11'h4EA);
`else
        chk("ext_done_latency", 32'(k), 32'd96);
        check_rx(2, 11'h7E0, 11'h4EA, 11'h0);
`endif

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
